// File: rtl/scan_led_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// FSM state encoding, digit-count limit and the output polarity helper.
package scan_led_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int MAX_DIGITS = 8;

  // Maps a logical "active" level to the pin level for the chosen polarity.
  function automatic logic apply_pol(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot counter shared by the SHOW and GAP phases: counts up from 0,
// flags the terminal count and restarts whenever the slot ends.
module scan_slot_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart_i,
  input  logic [CW-1:0] last_i,
  output logic [CW-1:0] cnt_next_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = restart_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_next_o = cnt_d;
  assign tc_o       = (cnt_q == last_i);

endmodule

// File: rtl/scan_led_mux.sv
// Parametrised scan driver for multiplexed 7-segment displays with frame snapshot,
// dot/blank masks and anti-ghosting gap. Optional macro: SCAN_LED_BRIGHTNESS_EN.
module scan_led_mux
  import scan_led_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_TICKS     = 50000,
  parameter int BLANK_TICKS    = 0,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int DOT_ACTIVE_LOW = 1
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dots_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SCAN_LED_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [3:0]              bcd_out,
  output logic                    dot_out,
  output logic [NUM_DIGITS-1:0]   led_sel,
  output logic                    frame_start
);

  localparam int MAXT = (SCAN_TICKS > BLANK_TICKS) ? SCAN_TICKS : BLANK_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_DIGITS - 1);
  localparam logic          SEL_LOW   = (SEL_ACTIVE_LOW != 0);
  localparam logic          DOT_LOW   = (DOT_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_LOW ? '1 : '0;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dots_q, dots_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    dot_q, dot_d;
  logic [NUM_DIGITS-1:0]   led_sel_q, led_sel_d;
  logic                    frame_start_q, frame_start_d;

  logic                    slot_end;
  logic                    next_digit;
  logic                    slot_tc;
  logic [CW-1:0]           slot_cnt_next;
  logic                    lit;
  logic                    bright_ok;
  logic [NUM_DIGITS-1:0]   sel_act;

  scan_slot_timer #(.CW(CW)) u_timer (
    .clk        (sys_clk),
    .rst        (rst),
    .restart_i  (slot_end),
    .last_i     ((state_q == GAP) ? GAP_LAST : SCAN_LAST),
    .cnt_next_o (slot_cnt_next),
    .tc_o       (slot_tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_end   = 1'b0;
    next_digit = 1'b0;
    case (state_q)
      LOAD: begin
        state_d  = SHOW;
        idx_d    = IDX_TOP;
        slot_end = 1'b1;
      end
      SHOW: if (slot_tc) begin
        slot_end = 1'b1;
        if (BLANK_TICKS > 0) state_d = GAP;
        else                 next_digit = 1'b1;
      end
      GAP: if (slot_tc) begin
        slot_end   = 1'b1;
        next_digit = 1'b1;
      end
      default: state_d = LOAD;
    endcase
    // Scan runs MSD first; wrapping past digit 0 starts a new frame.
    if (next_digit) begin
      if (idx_q != '0) begin
        state_d = SHOW;
        idx_d   = idx_q - 1'b1;
      end else begin
        state_d = LOAD;
      end
    end
  end

  assign digits_d = (state_q == LOAD) ? digits_in : digits_q;
  assign dots_d   = (state_q == LOAD) ? dots_in   : dots_q;
  assign blank_d  = (state_q == LOAD) ? blank_in  : blank_q;

`ifdef SCAN_LED_BRIGHTNESS_EN
  localparam int PHASE_DIV = (SCAN_TICKS >= 16) ? SCAN_TICKS / 16 : 1;
  logic [3:0] bright_q, bright_d;
  assign bright_d  = (state_q == LOAD) ? brightness : bright_q;
  assign bright_ok = (int'(slot_cnt_next) / PHASE_DIV) <= int'(bright_d);
`else
  logic unused_cnt;
  assign unused_cnt = ^slot_cnt_next;
  assign bright_ok  = 1'b1;
`endif

  // Outputs are derived from next-state values so they change on the same edge as the FSM.
  assign lit = (state_d == SHOW) && !blank_d[idx_d] && bright_ok;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
      assign sel_act[gi]   = lit && (idx_d == IW'(gi));
      assign led_sel_d[gi] = apply_pol(sel_act[gi], SEL_LOW);
    end
  endgenerate

  always_comb begin
    bcd_d         = bcd_q;
    dot_d         = apply_pol(lit && dots_d[idx_d], DOT_LOW);
    frame_start_d = (state_d == LOAD);
    if (state_d == SHOW) bcd_d = digits_d[int'(idx_d)*4 +: 4];
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD;
      idx_q         <= IDX_TOP;
      digits_q      <= '0;
      dots_q        <= '0;
      blank_q       <= '0;
      bcd_q         <= '0;
      dot_q         <= DOT_LOW;
      led_sel_q     <= SEL_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      digits_q      <= digits_d;
      dots_q        <= dots_d;
      blank_q       <= blank_d;
      bcd_q         <= bcd_d;
      dot_q         <= dot_d;
      led_sel_q     <= led_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef SCAN_LED_BRIGHTNESS_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) bright_q <= '0;
    else     bright_q <= bright_d;
  end
`endif

  assign bcd_out     = bcd_q;
  assign dot_out     = dot_q;
  assign led_sel     = led_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_led_mux.sv
// Self-checking bench for scan_led_mux: 4-digit active-low instance plus a
// 1-digit active-high zero-gap instance, both tracked by a frame-position model.
module tb_scan_led_mux;

  localparam int N    = 4;
  localparam int S    = 16;
  localparam int B    = 2;
  localparam int SLOT = S + B;
  localparam int F    = N * SLOT + 1;
  localparam int FB   = S + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dots, blank;
  logic [3:0]  bright;
  logic [3:0]  bcd_a, sel_a;
  logic        dot_a, fs_a;
  logic [3:0]  dig_b, bcd_b;
  logic        dots_b, blank_b, dot_b, fs_b;
  logic [0:0]  sel_b;

  int n_checks = 0;
  int n_pass   = 0;
  int tbpos    = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  scan_led_mux #(
    .NUM_DIGITS(N), .SCAN_TICKS(S), .BLANK_TICKS(B),
    .SEL_ACTIVE_LOW(1), .DOT_ACTIVE_LOW(1)
  ) dut_a (
    .sys_clk(clk), .rst(rst),
    .digits_in(digits), .dots_in(dots), .blank_in(blank),
`ifdef SCAN_LED_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .bcd_out(bcd_a), .dot_out(dot_a), .led_sel(sel_a), .frame_start(fs_a)
  );

  scan_led_mux #(
    .NUM_DIGITS(1), .SCAN_TICKS(S), .BLANK_TICKS(0),
    .SEL_ACTIVE_LOW(0), .DOT_ACTIVE_LOW(1)
  ) dut_b (
    .sys_clk(clk), .rst(rst),
    .digits_in(dig_b), .dots_in(dots_b), .blank_in(blank_b),
`ifdef SCAN_LED_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .bcd_out(bcd_b), .dot_out(dot_b), .led_sel(sel_b), .frame_start(fs_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model A: expectation from position within the frame (0 = LOAD cycle).
  int          pos;
  bit          first;
  logic [15:0] m_dig;
  logic [3:0]  m_dots, m_blank, m_bright, m_bcd;

  always @(negedge clk) begin : mon_a
    int q, d, off, lim;
    logic [3:0] e_sel, e_bcd;
    logic e_dot, e_fs;
    if (mon_en) begin
      e_sel = 4'hF; e_dot = 1'b1; e_fs = 1'b0;
      if (rst) begin
        pos = 0; first = 1'b1; m_bcd = 4'h0;
      end else begin
        if (pos == 0) begin
          e_fs = !first; first = 1'b0;
          m_dig = digits; m_dots = dots; m_blank = blank; m_bright = bright;
        end else begin
          q = pos - 1; d = N - 1 - q / SLOT; off = q % SLOT;
`ifdef SCAN_LED_BRIGHTNESS_EN
          lim = int'(m_bright);
`else
          lim = 15;
`endif
          if (off < S) begin
            m_bcd = m_dig[4*d +: 4];
            if (!m_blank[d] && (off / (S / 16)) <= lim) begin
              e_sel[d] = 1'b0;
              e_dot = !m_dots[d];
            end
          end
        end
        pos = (pos + 1) % F;
      end
      e_bcd = m_bcd;
      check("a_sel", 32'(sel_a), 32'(e_sel));
      check("a_bcd", 32'(bcd_a), 32'(e_bcd));
      check("a_dot", 32'(dot_a), 32'(e_dot));
      check("a_frame_start", 32'(fs_a), 32'(e_fs));
    end
  end

  // Model B: single digit, no gap, active-high select.
  int         pb;
  bit         firstb;
  logic [3:0] m_digb, m_brightb, m_bcdb;

  always @(negedge clk) begin : mon_b
    int lim;
    logic e_sel, e_dot, e_fs;
    if (mon_en) begin
      e_sel = 1'b0; e_dot = 1'b1; e_fs = 1'b0;
      if (rst) begin
        pb = 0; firstb = 1'b1; m_bcdb = 4'h0;
      end else begin
        if (pb == 0) begin
          e_fs = !firstb; firstb = 1'b0;
          m_digb = dig_b; m_brightb = bright;
        end else begin
`ifdef SCAN_LED_BRIGHTNESS_EN
          lim = int'(m_brightb);
`else
          lim = 15;
`endif
          m_bcdb = m_digb;
          if ((pb - 1) / (S / 16) <= lim) begin
            e_sel = 1'b1; e_dot = 1'b0;
          end
        end
        pb = (pb + 1) % FB;
      end
      check("b_sel", 32'(sel_b), 32'(e_sel));
      check("b_bcd", 32'(bcd_b), 32'(m_bcdb));
      check("b_dot", 32'(dot_b), 32'(e_dot));
      check("b_frame_start", 32'(fs_b), 32'(e_fs));
    end
  end

  task automatic wait_fs();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (fs_a !== 1'b1 && n < 200);
    check("fs_wait", 32'(fs_a), 32'd1);
    tbpos = 0;
  endtask

  task automatic goto(input int p);
    repeat (p - tbpos) @(negedge clk);
    tbpos = p;
  endtask

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic [3:0]  exp_on;
    logic [3:0]  exp_dot;
  } vec_t;

  vec_t vecs[4];

  initial begin : stim
    int n, d;
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    vecs[1] = '{16'h1234, 4'b0010, 4'b1000, 4'b0111, 4'b0010};
    vecs[2] = '{16'h90A7, 4'b1111, 4'b0101, 4'b1010, 4'b1010};
    vecs[3] = '{16'hFEDC, 4'b1001, 4'b0000, 4'b1111, 4'b1001};

    digits = 16'h1234; dots = 4'h0; blank = 4'h0; bright = 4'd3;
    dig_b = 4'h9; dots_b = 1'b1; blank_b = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset_sel", 32'(sel_a), 32'hF);
    check("reset_fs", 32'(fs_a), 32'h0);
    @(posedge clk); mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Frame period.
    wait_fs();
    n = 0;
    do begin @(negedge clk); n++; end while (fs_a !== 1'b1 && n < 200);
    check("frame_period", 32'(n), 32'd73);
    tbpos = 0;

    // Tear-free update while digit 2 is on.
    goto(1 + SLOT + 5);
    @(posedge clk); #1 digits = 16'h5678;
    goto(1 + 2*SLOT + 8);
    check("tear_d1", 32'(bcd_a), 32'h3);
    goto(1 + 3*SLOT + 8);
    check("tear_d0", 32'(bcd_a), 32'h4);
    wait_fs();
    goto(1 + 2);
    check("new_d3", 32'(bcd_a), 32'h5);

    // Table of mask patterns.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      digits = vecs[i].dig; dots = vecs[i].dots; blank = vecs[i].blank;
      wait_fs();
      for (int k = 0; k < N; k++) begin
        d = N - 1 - k;
        goto(1 + k*SLOT + 2);
        check("vec_bcd", 32'(bcd_a), 32'(vecs[i].dig[4*d +: 4]));
        check("vec_sel", 32'(sel_a), vecs[i].exp_on[d] ? 32'(~(4'b0001 << d) & 4'hF) : 32'hF);
        check("vec_dot", 32'(dot_a), 32'(!vecs[i].exp_dot[d]));
        goto(1 + k*SLOT + S);
        check("vec_gap_sel", 32'(sel_a), 32'hF);
      end
      $display("vector %0d digits=%h dots=%b blank=%b checked", i, vecs[i].dig, vecs[i].dots, vecs[i].blank);
    end

    // Asynchronous reset in the middle of a SHOW slot.
    wait_fs();
    goto(1 + 5);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_sel", 32'(sel_a), 32'hF);
    check("arst_bcd", 32'(bcd_a), 32'h0);
    check("arst_dot", 32'(dot_a), 32'h1);
    check("arst_sel_b", 32'(sel_b), 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check("arst_load", 32'(sel_a), 32'hF);
    @(negedge clk); check("arst_digit3", 32'(sel_a), 32'h7);

    // Random inputs changed at arbitrary points, tracked cycle by cycle.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 100)) @(posedge clk);
      #1;
      digits = 16'($urandom);
      dots   = 4'($urandom_range(0, 15));
      blank  = 4'($urandom_range(0, 15));
      dig_b  = 4'($urandom_range(0, 15));
      bright = 4'($urandom_range(0, 15));
      $display("random %0d digits=%h dots=%b blank=%b bright=%0d", r, digits, dots, blank, bright);
    end
    repeat (2*F) @(posedge clk);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_led_mux.md
Name: scan_led_mux

Overview:
Parametrised successor to the fixed 5-digit scan driver for multiplexed 7-segment displays. It time-multiplexes NUM_DIGITS BCD nibbles onto one shared bcd_out/dot_out bus and drives one select line per digit. New relative to the fixed driver:
- per-digit dot and blank masks
- tear-free frame snapshot of the inputs
- programmable anti-ghosting gap between digits
- frame-start strobe

It sits between the value formatter (for example the LM75 temperature-to-BCD path) and the board's BCD-to-segment decoder.

Parameters:
- NUM_DIGITS, 6: number of digits, legal range 1..8.
- SCAN_TICKS, 50000: sys_clk cycles each digit is selected (1 ms at 50 MHz). Must be >= 2.
- BLANK_TICKS, 0: cycles with all selects inactive after each digit slot. 0 means no gap.
- SEL_ACTIVE_LOW, 1: 1 means a selected digit drives its led_sel bit to 0.
- DOT_ACTIVE_LOW, 1: 1 means a lit dot drives dot_out to 0.

Ports:
- sys_clk, input, 1: system clock.
- rst, input, 1: reset.
- digits_in, input, 4*NUM_DIGITS: digit k is the nibble [4k+3:4k].
- dots_in, input, NUM_DIGITS: 1 means the dot of digit k is lit.
- blank_in, input, NUM_DIGITS: 1 means digit k is suppressed.
- bcd_out, output, 4: nibble for the currently selected digit.
- dot_out, output, 1: dot for the current digit, polarity set by DOT_ACTIVE_LOW.
- led_sel, output, NUM_DIGITS: bit k selects digit k, polarity set by SEL_ACTIVE_LOW.
- frame_start, output, 1: one-cycle pulse when a new snapshot is taken.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst high, asynchronous) clears these registers:
  - bcd_out = 0
  - dot_out = inactive
  - led_sel = all inactive
  - frame_start = 0
  - snapshot registers = 0
  - state = LOAD, digit index = NUM_DIGITS-1, slot counter = 0
- Reset asserted mid-frame takes effect immediately, with no partial slot completed.
- All outputs are registered and updated on the same edge as the state transition.
- FSM states:
  - LOAD (1 cycle):
    - Snapshot digits_in, dots_in, blank_in (and brightness, if the optional feature is compiled in).
    - Pulse frame_start = 1.
    - All selects inactive.
    - Next state: SHOW, index = NUM_DIGITS-1.
  - SHOW (SCAN_TICKS cycles):
    - bcd_out = snapshot nibble[index].
    - led_sel[index] active and all other bits inactive.
    - dot_out active iff dot[index] is set and blank[index] is clear.
    - If blank[index] is set, the slot duration is unchanged but led_sel stays all-inactive.
    - At the end of the slot: if BLANK_TICKS > 0, next state is GAP; otherwise go straight to the next-digit decision.
  - GAP (BLANK_TICKS cycles):
    - led_sel all inactive, dot_out inactive, bcd_out holds.
  - Next-digit decision:
    - If index > 0: decrement index, enter SHOW.
    - If index == 0: enter LOAD.
- Scan order runs from the most-significant digit (NUM_DIGITS-1) down to 0.
- Frame period = NUM_DIGITS*(SCAN_TICKS+BLANK_TICKS)+1 cycles.
- Input changes mid-frame are invisible until the next LOAD. No digit mixes old and new values.
- Counter widths:
  - Slot counter: $clog2(max(SCAN_TICKS,BLANK_TICKS)+1) bits, wraps to 0 on every state change.
  - Index: $clog2(NUM_DIGITS) bits, minimum 1 bit.
- With NUM_DIGITS = 1, index is fixed at 0 and the FSM alternates LOAD → SHOW → (GAP) → LOAD.
- At most one led_sel bit is active in any cycle.

Optional Feature:
Macro: SCAN_LED_BRIGHTNESS_EN

- Defined:
  - Adds input port brightness [3:0], sampled in LOAD.
  - SCAN_TICKS must be a multiple of 16.
  - Within SHOW, phase = slot_cnt / (SCAN_TICKS/16).
  - The select is active only while phase <= brightness. Otherwise led_sel and dot_out are inactive.
  - brightness = 15 gives full on-time; brightness = 0 gives 1/16 on-time.
  - Slot timing is unchanged.
- Undefined:
  - No brightness port; full on-time.

Decomposition:
- Shared package scan_led_pkg holds:
  - the state enum (LOAD, SHOW, GAP)
  - the digit-count limit constant MAX_DIGITS = 8
  - a polarity helper function applying the SEL/DOT active-low parameters
- One sub-module, scan_slot_timer: the slot counter with a load value and a terminal-count pulse. It is shared by SHOW and GAP.

Test Plan:
1. Reset and frame timing. NUM_DIGITS=4, SCAN_TICKS=16, BLANK_TICKS=2, digits_in=16'h1234; release rst.
   - frame_start pulses every 73 cycles.
   - led_sel walks 0111 → 1011 → 1101 → 1110, each for 16 cycles, with 2 all-ones cycles between.
   - bcd_out shows 1, 2, 3, 4 in its slots.
2. Tear-free update. Change digits_in to 16'h5678 while digit 2 is shown.
   - The remaining slots of the current frame still show 2, 3, 4.
   - The next frame shows 5, 6, 7, 8.
3. Masks. dots_in=4'b0010, blank_in=4'b1000.
   - The digit-3 slot lasts 16 cycles with led_sel=4'b1111 and dot_out=1.
   - dot_out=0 only during the digit-1 slot.
4. Asynchronous reset mid-SHOW. Assert rst mid-slot, between clock edges.
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - After release, the sequence restarts with LOAD and then digit 3.
5. Zero gap and polarity. BLANK_TICKS=0, SEL_ACTIVE_LOW=0, NUM_DIGITS=1.
   - led_sel=1 for 16 cycles, then 0 for 1 cycle (LOAD), repeating.
6. Brightness. SCAN_LED_BRIGHTNESS_EN defined, brightness=3, SCAN_TICKS=16.
   - Each select is active for the first 4 cycles of its 16-cycle slot.
